// File: rtl/fxp_mac_pipe.sv
// Three-stage signed fixed-point MUL/MAC/MSUB/CLEAR unit with a guarded accumulator and
// a rounded, saturated output. Optional out_sat_sticky port: define FXP_MAC_STICKY_SAT_EN.
module fxp_mac_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FRAC_W  = 16,
    parameter int unsigned GUARD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat
`ifdef FXP_MAC_STICKY_SAT_EN
    ,
    output logic              out_sat_sticky
`endif
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = 2 * DATA_W + GUARD_W;

    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W:0]   Half   = (ACC_W+1)'(1) << (FRAC_W - 1);
    localparam logic [ACC_W:0]   PosLim = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic [ACC_W:0]   NegLim = PosLim + (ACC_W+1)'(1);

    typedef enum logic [1:0] {
        OpMul   = 2'b00,
        OpMac   = 2'b01,
        OpMsub  = 2'b10,
        OpClear = 2'b11
    } op_e;

    logic              stall;

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_a_q;
    logic [DATA_W-1:0] s1_b_q;
    op_e               s1_op_q;

    logic              s2_valid_q;
    logic [PROD_W-1:0] s2_p_q;
    op_e               s2_op_q;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_sat_q;
    logic [ACC_W-1:0]  acc_q;

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod;

    logic [ACC_W:0]    p_ext;
    logic [ACC_W:0]    acc_ext;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  acc_d;
    logic              acc_clamp;

    logic              acc_neg;
    logic [ACC_W-1:0]  mag;
    logic [ACC_W:0]    rnd;
    logic [ACC_W:0]    r_mag;
    logic [DATA_W-1:0] res_d;
    logic              out_clamp;
    logic              sat_d;

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // Low PROD_W bits of the sign-extended product equal the signed full product.
    assign a_ext = {{DATA_W{s1_a_q[DATA_W-1]}}, s1_a_q};
    assign b_ext = {{DATA_W{s1_b_q[DATA_W-1]}}, s1_b_q};
    assign prod  = a_ext * b_ext;

    // Accumulator update; one extra bit detects overflow of the ACC_W range.
    always_comb begin
        p_ext     = {{(ACC_W+1-PROD_W){s2_p_q[PROD_W-1]}}, s2_p_q};
        acc_ext   = {acc_q[ACC_W-1], acc_q};
        sum       = '0;
        acc_d     = '0;
        acc_clamp = 1'b0;
        unique case (s2_op_q)
            OpMul:   sum = p_ext;
            OpMac:   sum = acc_ext + p_ext;
            OpMsub:  sum = acc_ext - p_ext;
            OpClear: sum = '0;
            default: sum = '0;
        endcase
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_clamp = 1'b1;
            acc_d     = sum[ACC_W] ? AccMin : AccMax;
        end else begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    // Round half away from zero on the magnitude, then restore sign and clamp.
    always_comb begin
        acc_neg   = acc_d[ACC_W-1];
        mag       = acc_neg ? (~acc_d + ACC_W'(1)) : acc_d;
        rnd       = {1'b0, mag} + Half;
        r_mag     = rnd >> FRAC_W;
        res_d     = '0;
        out_clamp = 1'b0;
        if (acc_neg) begin
            if (r_mag > NegLim) begin
                out_clamp = 1'b1;
                res_d     = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                res_d = ~r_mag[DATA_W-1:0] + DATA_W'(1);
            end
        end else begin
            if (r_mag > PosLim) begin
                out_clamp = 1'b1;
                res_d     = {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                res_d = r_mag[DATA_W-1:0];
            end
        end
        sat_d = out_clamp | acc_clamp;
    end

    // The whole pipe advances together; a stall freezes every stage and acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OpMul;
            s2_valid_q  <= 1'b0;
            s2_p_q      <= '0;
            s2_op_q     <= OpMul;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            acc_q       <= '0;
        end else if (!stall) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q  <= in_a;
                s1_b_q  <= in_b;
                s1_op_q <= op_e'(in_op);
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_p_q  <= prod;
                s2_op_q <= s1_op_q;
            end
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                acc_q      <= acc_d;
                out_data_q <= res_d;
                out_sat_q  <= sat_d;
            end
        end
    end

`ifdef FXP_MAC_STICKY_SAT_EN
    logic sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (!stall && s2_valid_q) begin
            if (s2_op_q == OpClear) begin
                sticky_q <= 1'b0;
            end else if (sat_d) begin
                sticky_q <= 1'b1;
            end
        end
    end

    assign out_sat_sticky = sticky_q;
`endif

endmodule
